ir_key_event: RTL

//  Consumes decoded 32-bit NEC frames from the IR receive stage and turns them into key events.
//  - Validates the frame's complement bytes and applies an optional address filter.
//  - Emits press, release and auto-repeat pulses, and tracks the held key.
//  - Sits between the IR decoder (code + new-code strobe + repeat strobe) and game/menu control logic.

---
 rtl/ir_pkg.sv | 12 +
 rtl/ir_cycle_timer.sv | 18 +
 rtl/ir_key_event.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared types, NEC frame field positions and the frame integrity check.
package ir_pkg;
    typedef enum logic [1:0] {IDLE, PRESSED, HELD, SWAP} key_state_t;
    localparam int ADDR_LSB  = 0;
    localparam int NADDR_LSB = 8;
    localparam int CMD_LSB   = 16;
    localparam int NCMD_LSB  = 24;
    function automatic logic nec_frame_ok(input logic [31:0] code);
        return ((code[ADDR_LSB +: 8] ^ code[NADDR_LSB +: 8]) == 8'hFF) &&
               ((code[CMD_LSB +: 8] ^ code[NCMD_LSB +: 8]) == 8'hFF);
    endfunction
endpackage

// File: rtl/ir_cycle_timer.sv
// ir_cycle_timer: saturating cycle counter; done_out once MAX cycles have elapsed since restart.
module ir_cycle_timer #(
    parameter int MAX = 100
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic restart_in,
    input  logic en_in,
    output logic done_out
);
    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);
    logic [W-1:0] cnt_q, cnt_d;
    // The restart cycle itself counts as the first elapsed cycle.
    always_comb cnt_d = restart_in ? W'(1) : (en_in && cnt_q != MAX_V) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_in) cnt_q <= rst_in ? '0 : cnt_d;
    assign done_out = cnt_q == MAX_V;
endmodule

// File: rtl/ir_key_event.sv
// ir_key_event: turns decoded NEC frames and repeat strobes into press/release/auto-repeat key events.
module ir_key_event
    import ir_pkg::*;
#(
    parameter int          RELEASE_CYCLES = 11_000_000,
    parameter int          HOLD_CYCLES    = 50_000_000,
    parameter int          REPEAT_CYCLES  = 10_000_000,
    parameter bit          FILTER_EN      = 1'b0,
    parameter logic [7:0]  ADDR_FILTER    = 8'h00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        code_valid_in,
    input  logic        repeat_in,
    output logic [7:0]  key_out,
    output logic        press_out,
    output logic        release_out,
    output logic        repeat_out,
    output logic        held_out,
    output logic        frame_err_out,
    output logic [7:0]  err_count_out
);
    key_state_t state_q, state_d;
    logic [7:0] key_q, key_d, pend_q, pend_d, err_q, err_d;
    logic press_q, press_d, release_q, release_d, rpt_q, rpt_d, held_q, held_d, ferr_q, ferr_d;
    logic rel_restart, hold_restart, rep_restart, rel_done, hold_done, rep_done;
    logic [7:0] cmd;
    logic frame_ok, accept, refresh;

    assign cmd      = code_in[CMD_LSB +: 8];
    assign frame_ok = nec_frame_ok(code_in);
    assign accept   = code_valid_in && frame_ok && (!FILTER_EN || code_in[ADDR_LSB +: 8] == ADDR_FILTER);
    // A frame strobe always takes precedence, so a simultaneous repeat strobe never refreshes.
    assign refresh  = code_valid_in ? (accept && cmd == key_q) : repeat_in;

    ir_cycle_timer #(.MAX(RELEASE_CYCLES)) u_release (
        .clk_in(clk_in), .rst_in(rst_in), .restart_in(rel_restart),
        .en_in(state_q == PRESSED || state_q == HELD), .done_out(rel_done)
    );
    ir_cycle_timer #(.MAX(HOLD_CYCLES)) u_hold (
        .clk_in(clk_in), .rst_in(rst_in), .restart_in(hold_restart),
        .en_in(state_q == PRESSED), .done_out(hold_done)
    );
    ir_cycle_timer #(.MAX(REPEAT_CYCLES)) u_repeat (
        .clk_in(clk_in), .rst_in(rst_in), .restart_in(rep_restart),
        .en_in(state_q == HELD), .done_out(rep_done)
    );

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        pend_d       = pend_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        rpt_d        = 1'b0;
        held_d       = held_q;
        rel_restart  = 1'b0;
        hold_restart = 1'b0;
        rep_restart  = 1'b0;
        ferr_d       = code_valid_in && !frame_ok;
        err_d        = (ferr_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    key_d        = cmd;
                    press_d      = 1'b1;
                    state_d      = PRESSED;
                    rel_restart  = 1'b1;
                    hold_restart = 1'b1;
                end
            end
            PRESSED, HELD: begin
                if (accept && cmd != key_q) begin
                    pend_d    = cmd;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    state_d   = SWAP;
                end else if (!refresh && rel_done) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    rel_restart = refresh;
                    if (state_q == PRESSED && hold_done) begin
                        state_d     = HELD;
                        held_d      = 1'b1;
                        rpt_d       = 1'b1;
                        rep_restart = 1'b1;
                    end
                    if (state_q == HELD && rep_done) begin
                        rpt_d       = 1'b1;
                        rep_restart = 1'b1;
                    end
                end
            end
            default: begin
                key_d        = pend_q;
                press_d      = 1'b1;
                state_d      = PRESSED;
                rel_restart  = 1'b1;
                hold_restart = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            key_q     <= '0;
            pend_q    <= '0;
            err_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
            held_q    <= held_d;
            ferr_q    <= ferr_d;
        end
    end

    assign key_out       = key_q;
    assign press_out     = press_q;
    assign release_out   = release_q;
    assign repeat_out    = rpt_q;
    assign held_out      = held_q;
    assign frame_err_out = ferr_q;
    assign err_count_out = err_q;
endmodule
